// File: rtl/dm_mem_pkg.sv
// Shared types and address-map helpers for the debug-memory responder.
// Region bases follow the usual debug-ROM layout; the decoder owns overlap checks.
package dm_mem_pkg;

    typedef enum logic [1:0] {
        FSM_IDLE     = 2'd0,
        FSM_CMD_GO   = 2'd1,
        FSM_CMD_EXEC = 2'd2,
        FSM_RESUME   = 2'd3
    } fsm_state_e;

    localparam int unsigned FLAG_GO_BIT     = 0;
    localparam int unsigned FLAG_RESUME_BIT = 1;

    localparam logic [31:0] WHERETO_ADDR = 32'h0000_0300;
    localparam logic [31:0] ABS_CMD_BASE = 32'h0000_0338;
    localparam logic [31:0] PROG_BASE    = 32'h0000_0360;
    localparam logic [31:0] DATA_BASE    = 32'h0000_0380;
    localparam logic [31:0] FLAGS_BASE   = 32'h0000_0400;

    function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr >> 2) - (base >> 2);
    endfunction

    function automatic logic [31:0] region_index(input logic [31:0] addr, input logic [31:0] base,
                                                 input logic [31:0] size);
        return word_offset(addr, base) % size;
    endfunction

endpackage

// File: rtl/dm_mem_rdmux.sv
// Combinational read-data selector for the debug-memory regions.
// Word indices wrap modulo the region size; flags only answer at word 0.
module dm_mem_rdmux
    import dm_mem_pkg::*;
#(
    parameter int          DataCount   = 2,
    parameter int          ProgBufSize = 8,
    parameter int          AbsCmdSize  = 10,
    parameter logic [31:0] WhereToInsn = 32'h0000_006F
) (
    input  logic                      rd_where_en,
    input  logic                      rd_data_en,
    input  logic                      rd_prog_en,
    input  logic                      rd_abs_cmd_en,
    input  logic                      rd_flags_en,
    input  logic [31:0]               rd_addr,
    input  logic [DataCount*32-1:0]   data_words,
    input  logic [ProgBufSize*32-1:0] prog_words,
    input  logic [AbsCmdSize*32-1:0]  abs_words,
    input  logic                      go_flag,
    input  logic                      resume_flag,
    output logic [31:0]               rdata
);

    logic [31:0] data_idx_s;
    logic [31:0] prog_idx_s;
    logic [31:0] abs_idx_s;
    logic [31:0] flags_off_s;
    logic [31:0] data_word_s;
    logic [31:0] prog_word_s;
    logic [31:0] abs_word_s;
    logic [31:0] flags_word_s;

    assign data_idx_s  = region_index(rd_addr, DATA_BASE, 32'(DataCount));
    assign prog_idx_s  = region_index(rd_addr, PROG_BASE, 32'(ProgBufSize));
    assign abs_idx_s   = region_index(rd_addr, ABS_CMD_BASE, 32'(AbsCmdSize));
    assign flags_off_s = word_offset(rd_addr, FLAGS_BASE);

    // Per-region word selection by indexed compare.
    always_comb begin
        data_word_s  = 32'h0;
        prog_word_s  = 32'h0;
        abs_word_s   = 32'h0;
        flags_word_s = 32'h0;
        for (int i = 0; i < DataCount; i++) begin
            data_word_s = (data_idx_s == 32'(i)) ? data_words[i*32 +: 32] : data_word_s;
        end
        for (int i = 0; i < ProgBufSize; i++) begin
            prog_word_s = (prog_idx_s == 32'(i)) ? prog_words[i*32 +: 32] : prog_word_s;
        end
        for (int i = 0; i < AbsCmdSize; i++) begin
            abs_word_s = (abs_idx_s == 32'(i)) ? abs_words[i*32 +: 32] : abs_word_s;
        end
        flags_word_s[FLAG_GO_BIT]     = go_flag;
        flags_word_s[FLAG_RESUME_BIT] = resume_flag;
    end

    // Region priority mux; no enable yields zero.
    always_comb begin
        rdata = 32'h0;
        if (rd_where_en) begin
            rdata = WhereToInsn;
        end else if (rd_data_en) begin
            rdata = data_word_s;
        end else if (rd_prog_en) begin
            rdata = prog_word_s;
        end else if (rd_abs_cmd_en) begin
            rdata = abs_word_s;
        end else if (rd_flags_en) begin
            rdata = (flags_off_s == 32'h0) ? flags_word_s : 32'h0;
        end else begin
            rdata = 32'h0;
        end
    end

endmodule

// File: rtl/dm_mem_resp.sv
// Debug-memory responder: registered read response, data write-back strobes
// and the single-hart halt/go/resume/exception handshake with the park loop.
module dm_mem_resp
    import dm_mem_pkg::*;
#(
    parameter int          BusWidth    = 32,
    parameter int          DataCount   = 2,
    parameter int          ProgBufSize = 8,
    parameter int          AbsCmdSize  = 10,
    parameter logic [31:0] WhereToInsn = 32'h0000_006F
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic [BusWidth-1:0]       wdata_i,
    input  logic [BusWidth/8-1:0]     be_i,
    input  logic                      wr_halted_en_i,
    input  logic                      wr_going_en_i,
    input  logic                      wr_resuming_en_i,
    input  logic                      wr_exception_en_i,
    input  logic                      wr_data_en_i,
    input  logic [BusWidth-1:0]       wr_data_addr_i,
    input  logic                      rd_where_en_i,
    input  logic                      rd_data_en_i,
    input  logic                      rd_prog_en_i,
    input  logic                      rd_abs_cmd_en_i,
    input  logic                      rd_flags_en_i,
    input  logic [BusWidth-1:0]       rd_addr_i,
    input  logic [DataCount*32-1:0]   data_i,
    input  logic [ProgBufSize*32-1:0] progbuf_i,
    input  logic [AbsCmdSize*32-1:0]  abs_cmd_i,
    input  logic                      resumereq_i,
    input  logic                      cmd_valid_i,
    output logic [BusWidth-1:0]       rdata_o,
    output logic                      rvalid_o,
    output logic [DataCount*32-1:0]   data_o,
    output logic [DataCount-1:0]      data_we_o,
    output logic                      halted_o,
    output logic                      resuming_o,
    output logic                      cmd_busy_o,
    output logic                      cmderr_exc_o
);

    fsm_state_e          state_r, state_s;
    logic                halted_r, halted_s;
    logic                cmd_busy_r, cmd_busy_s;
    logic                go_flag_r, go_flag_s;
    logic                resume_flag_r, resume_flag_s;
    logic                resuming_r, resuming_s;
    logic                cmderr_r, cmderr_s;
    logic                rvalid_r;
    logic [BusWidth-1:0] rdata_r;
    logic [31:0]         mux_rdata_s;
    logic [31:0]         wr_off_s;

    dm_mem_rdmux #(
        .DataCount   (DataCount),
        .ProgBufSize (ProgBufSize),
        .AbsCmdSize  (AbsCmdSize),
        .WhereToInsn (WhereToInsn)
    ) u_rdmux (
        .rd_where_en   (rd_where_en_i),
        .rd_data_en    (rd_data_en_i),
        .rd_prog_en    (rd_prog_en_i),
        .rd_abs_cmd_en (rd_abs_cmd_en_i),
        .rd_flags_en   (rd_flags_en_i),
        .rd_addr       (rd_addr_i[31:0]),
        .data_words    (data_i),
        .prog_words    (progbuf_i),
        .abs_words     (abs_cmd_i),
        .go_flag       (go_flag_r),
        .resume_flag   (resume_flag_r),
        .rdata         (mux_rdata_s)
    );

    assign wr_off_s = word_offset(wr_data_addr_i[31:0], DATA_BASE);

    // Data write-back: byte-merge into the addressed word, strobe only in range.
    always_comb begin
        data_o    = data_i;
        data_we_o = '0;
        for (int i = 0; i < DataCount; i++) begin
            if (wr_data_en_i && (wr_off_s == 32'(i))) begin
                for (int b = 0; b < 4; b++) begin
                    data_o[i*32 + b*8 +: 8] = be_i[b] ? wdata_i[b*8 +: 8] : data_i[i*32 + b*8 +: 8];
                end
                data_we_o[i] = 1'b1;
            end else begin
                data_we_o[i] = 1'b0;
            end
        end
    end

    // Handshake FSM next-state; a command beats a resume request in the same cycle,
    // and a halted write beats an exception while executing.
    always_comb begin
        state_s    = state_r;
        halted_s   = halted_r;
        resuming_s = 1'b0;
        cmderr_s   = 1'b0;
        case (state_r)
            FSM_IDLE: begin
                halted_s = halted_r | wr_halted_en_i;
                if (cmd_valid_i && halted_r) begin
                    state_s = FSM_CMD_GO;
                end else if (resumereq_i && halted_r) begin
                    state_s = FSM_RESUME;
                end else begin
                    state_s = FSM_IDLE;
                end
            end
            FSM_CMD_GO: begin
                if (wr_going_en_i) begin
                    state_s = FSM_CMD_EXEC;
                end else begin
                    state_s = FSM_CMD_GO;
                end
            end
            FSM_CMD_EXEC: begin
                if (wr_halted_en_i) begin
                    state_s = FSM_IDLE;
                end else if (wr_exception_en_i) begin
                    state_s  = FSM_IDLE;
                    cmderr_s = 1'b1;
                end else begin
                    state_s = FSM_CMD_EXEC;
                end
            end
            FSM_RESUME: begin
                if (wr_resuming_en_i) begin
                    state_s    = FSM_IDLE;
                    halted_s   = 1'b0;
                    resuming_s = 1'b1;
                end else begin
                    state_s = FSM_RESUME;
                end
            end
            default: begin
                state_s  = FSM_IDLE;
                halted_s = 1'b0;
            end
        endcase
        go_flag_s     = (state_s == FSM_CMD_GO);
        resume_flag_s = (state_s == FSM_RESUME);
        cmd_busy_s    = (state_s == FSM_CMD_GO) || (state_s == FSM_CMD_EXEC);
    end

    // State, flag and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= FSM_IDLE;
            halted_r      <= 1'b0;
            cmd_busy_r    <= 1'b0;
            go_flag_r     <= 1'b0;
            resume_flag_r <= 1'b0;
            resuming_r    <= 1'b0;
            cmderr_r      <= 1'b0;
            rvalid_r      <= 1'b0;
            rdata_r       <= {BusWidth{1'b0}};
        end else begin
            state_r       <= state_s;
            halted_r      <= halted_s;
            cmd_busy_r    <= cmd_busy_s;
            go_flag_r     <= go_flag_s;
            resume_flag_r <= resume_flag_s;
            resuming_r    <= resuming_s;
            cmderr_r      <= cmderr_s;
            rvalid_r      <= req_i;
            rdata_r       <= req_i ? BusWidth'(mux_rdata_s) : {BusWidth{1'b0}};
        end
    end

    assign rdata_o      = rdata_r;
    assign rvalid_o     = rvalid_r;
    assign halted_o     = halted_r;
    assign resuming_o   = resuming_r;
    assign cmd_busy_o   = cmd_busy_r;
    assign cmderr_exc_o = cmderr_r;

endmodule

// File: doc/dm_mem_resp.md
Name: dm_mem_resp

Overview:
Responder half of the debug-memory slave port: consumes the per-region enables produced by the DM address decoder and services them, returning registered read data and one-cycle-later response valid to the hart bus. Owns the single-hart halt/go/resume/exception state machine, the data-register write path back to the DM CSR block, and the flags word the park loop polls. Sits between the decoder and the DM CSR/abstract-command logic.

Parameters:
BusWidth, 32, bus data/address width
DataCount, 2, number of abstract data words
ProgBufSize, 8, program-buffer words
AbsCmdSize, 10, abstract-command words
WhereToInsn, 32'h0000_006F, instruction word returned on a whereto read (JAL to abstract-command base; set at integration)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
req_i  in  1  bus request, forwarded by decoder
wdata_i  in  BusWidth  write data
be_i  in  BusWidth/8  byte enables for data writes
wr_halted_en_i, wr_going_en_i, wr_resuming_en_i, wr_exception_en_i  in  1 each  decoded write strobes
wr_data_en_i  in  1  data-region write
wr_data_addr_i  in  BusWidth  data write address
rd_where_en_i, rd_data_en_i, rd_prog_en_i, rd_abs_cmd_en_i, rd_flags_en_i  in  1 each  decoded read strobes
rd_addr_i  in  BusWidth  read address
data_i  in  DataCount*32  current data registers
progbuf_i  in  ProgBufSize*32  program buffer
abs_cmd_i  in  AbsCmdSize*32  generated abstract command
resumereq_i  in  1  resume request (level)
cmd_valid_i  in  1  abstract command issued (one-cycle pulse)
rdata_o  out  BusWidth  read data
rvalid_o  out  1  response valid
data_o  out  DataCount*32  write-back value
data_we_o  out  DataCount  per-word write strobe
halted_o  out  1  hart parked
resuming_o  out  1  resume acknowledge pulse
cmd_busy_o  out  1  abstract command in flight
cmderr_exc_o  out  1  exception-during-command pulse

Behaviour:
- Reset (rst_ni low, async): rdata_o=0, rvalid_o=0, data_we_o=0, halted_o=0, resuming_o=0, cmd_busy_o=0, cmderr_exc_o=0, FSM=IDLE, flags=0.
- Response: rvalid_o registered req_i (latency 1, every request answered, writes included); rdata_o registered from mux below, 0 for writes or no enable hit.
- Read mux (word index = rd_addr_i[..:2] minus region base, modulo region size): where -> WhereToInsn; data -> data_i word; prog -> progbuf_i word; abs_cmd -> abs_cmd_i word; flags -> {30'b0, resume_flag, go_flag} if word index 0, else 0.
- Data write: data_o = selected data_i word with bytes replaced per be_i; data_we_o one-hot for the word, asserted same cycle as wr_data_en_i (combinational strobe, registered data source not required). Out-of-range index: no strobe.
- FSM states IDLE, CMD_GO, CMD_EXEC, RESUME:
  IDLE: wr_halted_en -> halted_o=1. cmd_valid_i && halted_o -> CMD_GO (go_flag=1, cmd_busy_o=1). resumereq_i && halted_o && !cmd_busy -> RESUME (resume_flag=1).
  CMD_GO: wr_going_en -> CMD_EXEC, go_flag=0.
  CMD_EXEC: wr_halted_en -> IDLE, cmd_busy_o=0. wr_exception_en -> cmderr_exc_o pulse 1 cycle, IDLE, cmd_busy_o=0.
  RESUME: wr_resuming_en -> resuming_o pulse 1 cycle, halted_o=0, resume_flag=0, IDLE.
- cmd_valid_i while not halted or busy: ignored (CSR block flags error). resumereq_i and cmd_valid_i same cycle in IDLE: command wins.
- wr_exception_en in IDLE/RESUME: ignored. wr_halted_en in RESUME: stays RESUME, halted_o held 1.
- Reset mid-command: all state cleared; no pulses emitted.

Decomposition:
- Package dm_mem_pkg: fsm_state_e, flag bit positions, region sizes/indices helpers.
- Sub-module dm_mem_rdmux: combinational read-data mux; FSM and registers in top.

Test Plan:
- Reset then read flags (rd_flags_en_i, addr 0x400) -> rvalid_o=1 next cycle, rdata_o=0.
- wr_halted_en, cmd_valid_i -> flags read returns 1; wr_going_en -> flags 0, cmd_busy_o=1; wr_halted_en -> cmd_busy_o=0.
- During CMD_EXEC wr_exception_en -> cmderr_exc_o single-cycle pulse, state IDLE, halted_o=1.
- Halted, resumereq_i -> flags read 2; wr_resuming_en -> resuming_o pulse, halted_o=0.
- Data write word 1, wdata 0xAABBCCDD, be 4'b0101, data_i word1 0x11223344 -> data_o word 0x11BB33DD, data_we_o=2'b10.
- rd_prog_en, word index 3, progbuf word3 0xDEADBEEF -> rdata_o 0xDEADBEEF one cycle later; async reset asserted in CMD_GO -> all outputs 0 immediately.
